// File: rtl/mem_store_buffer_pkg.sv
// Shared constants and the store-buffer entry record for the data-memory path.
// Ports: none (package). SB_DEPTH / WORD_ADDR_W / DATA_W set the default buffer geometry.
// sb_entry_t is the record kept per buffered store.
package mem_pkg;

  localparam int SB_DEPTH    = 4;
  localparam int WORD_ADDR_W = 32;
  localparam int DATA_W      = 32;

  typedef struct packed {
    logic                   valid;
    logic [WORD_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]      data;
  } sb_entry_t;

endpackage

// File: rtl/mem_store_buffer_if.sv
// Bundle between the store buffer, the MEM-stage pipeline register and the data memory.
// Pipeline side: st_valid/st_addr/st_data, ld_valid/ld_addr -> ld_data, stall, empty, count.
// Memory side: mem_we/mem_addr/mem_wd -> mem_rd (combinational read data).
interface mem_store_buffer_if #(
  parameter int DEPTH  = mem_pkg::SB_DEPTH,
  parameter int ADDR_W = mem_pkg::WORD_ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
);
  import mem_pkg::*;

  logic                       st_valid;
  logic [ADDR_W-1:0]          st_addr;
  logic [DATA_W-1:0]          st_data;
  logic                       ld_valid;
  logic [ADDR_W-1:0]          ld_addr;
  logic [DATA_W-1:0]          ld_data;
  logic                       stall;
  logic                       empty;
  logic [$clog2(DEPTH):0]     count;
  logic                       mem_we;
  logic [ADDR_W-1:0]          mem_addr;
  logic [DATA_W-1:0]          mem_wd;
  logic [DATA_W-1:0]          mem_rd;

  // Store buffer view.
  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rd,
    output ld_data, stall, empty, count, mem_we, mem_addr, mem_wd
  );

  // Pipeline + memory view.
  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_rd,
    input  ld_data, stall, empty, count, mem_we, mem_addr, mem_wd
  );

endinterface

// File: rtl/mem_store_buffer_fifo.sv
// sb_fifo: circular store storage with head/tail pointers, occupancy count and full/empty.
// Ports: CLK, reset (async low), push/push_addr/push_data, pop -> entries[], head, tail, count, full, empty.
// Every entry plus the tail pointer is exposed so the parent can search for forwarding hits.
module sb_fifo #(
  parameter  int DEPTH = mem_pkg::SB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                            CLK,
  input  logic                            reset,
  input  logic                            push,
  input  logic [mem_pkg::WORD_ADDR_W-1:0] push_addr,
  input  logic [mem_pkg::DATA_W-1:0]      push_data,
  input  logic                            pop,
  output mem_pkg::sb_entry_t              entries [DEPTH],
  output logic [PTR_W-1:0]                head,
  output logic [PTR_W-1:0]                tail,
  output logic [CNT_W-1:0]                count,
  output logic                            full,
  output logic                            empty
);
  import mem_pkg::*;

  logic do_push;
  logic do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      // Drained slots are invalidated so the forwarding search ignores them.
      if (do_pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + PTR_W'(1);
      end
      if (do_push) begin
        entries[tail] <= '{valid: 1'b1, addr: push_addr, data: push_data};
        tail          <= tail + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/mem_store_buffer.sv
// mem_store_buffer: write-posting buffer between the MEM stage and a single-port data memory.
// Ports: CLK, reset (async low), sb (slave modport: store/load requests, stall/empty/count, memory port).
// Loads own the memory port and get zero-latency data (forwarded or mem_rd); stores drain when idle.
module mem_store_buffer #(
  parameter int DEPTH  = mem_pkg::SB_DEPTH,
  parameter int ADDR_W = mem_pkg::WORD_ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
) (
  input  logic               CLK,
  input  logic               reset,
  mem_store_buffer_if.slave  sb
);
  import mem_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t          entries [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  logic               fwd_hit;
  logic [DATA_W-1:0]  fwd_data;
  logic [ADDR_W-1:0]  drain_addr;
  logic [PTR_W-1:0]   idx;

  // Full means stall even if a drain frees a slot this same edge.
  assign push = sb.st_valid & ~full;
  // The load has priority on the port; drain only in cycles without a load.
  assign pop  = ~sb.ld_valid & ~fifo_empty;

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .reset     (reset),
    .push      (push),
    .push_addr (sb.st_addr),
    .push_data (sb.st_data),
    .pop       (pop),
    .entries   (entries),
    .head      (head),
    .tail      (tail),
    .count     (count),
    .full      (full),
    .empty     (fifo_empty)
  );

  assign sb.stall = sb.st_valid & full;
  assign sb.empty = fifo_empty;
  assign sb.count = count;

  // Youngest-first search: walk backwards from tail, first valid match wins.
  // The store accepted this cycle is not yet in storage, so it is never seen.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = tail - PTR_W'(k + 1);
      if (!fwd_hit && entries[idx].valid && (entries[idx].addr == sb.ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[idx].data;
      end
    end
  end

  assign sb.ld_data = fwd_hit ? fwd_data : sb.mem_rd;

  // Port mux: load address, else head-of-queue write, else idle zeros.
  assign drain_addr = entries[head].addr;

  always_comb begin
    sb.mem_we   = 1'b0;
    sb.mem_addr = '0;
    sb.mem_wd   = '0;
    if (sb.ld_valid) begin
      sb.mem_addr = sb.ld_addr;
    end else if (!fifo_empty) begin
      sb.mem_we   = 1'b1;
      sb.mem_addr = drain_addr;
      sb.mem_wd   = entries[head].data;
    end
  end

endmodule
